// File: rtl/axis_gcd_pkg.sv
// rtl/axis_gcd_pkg.sv - shared state type and width helper for the stream GCD engine
package axis_gcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2
  } gcd_state_t;

  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_gcd_stream_if.sv
// rtl/axis_gcd_stream_if.sv - stream bundle (tdata/tvalid/tready/tlast) with master/slave views
interface axis_gcd_stream_if #(
  parameter int W = 32
);

  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/gcd_stein_core.sv
// rtl/gcd_stein_core.sv - iterative binary (Stein) GCD, one reduction step per cycle
module gcd_stein_core
  import axis_gcd_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] r
);

  localparam int K_W = clog2(DATA_W) + 1;
  localparam logic [K_W-1:0] K_ONE = K_W'(1);

  gcd_state_t        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] r_q, r_d;
  logic [K_W-1:0]    k_q, k_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // k counts the common factors of two removed so far; restored on exit
        if (a_q == '0) begin
          r_d     = b_q << k_q;
          state_d = WRITE;
        end else if (b_q == '0) begin
          r_d     = a_q << k_q;
          state_d = WRITE;
        end else if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + K_ONE;
        end else if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q >= b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign done = (state_q == WRITE);
  assign r    = r_q;

endmodule

// File: rtl/axis_gcd_stream.sv
// rtl/axis_gcd_stream.sv - stream GCD wrapper: input handshake, tlast tracking, result FIFO
module axis_gcd_stream
  import axis_gcd_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              aclk,
  input  logic              areset,
  axis_gcd_stream_if.slave  s_axis,
  axis_gcd_stream_if.master m_axis,
  output logic              busy
);

  localparam int PTR_W = clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic              rdy_en;
  logic              core_busy;
  logic              tlast_q;
  logic              accept;
  logic              push;
  logic              pop;
  logic              core_done;
  logic [DATA_W-1:0] core_res;
  logic [DATA_W:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  // Only one pair is ever in flight, so a free slot at accept is a slot at WRITE
  assign s_axis.tready = rdy_en && !core_busy && (count < FULL_CNT);
  assign accept        = s_axis.tvalid && s_axis.tready;
  assign push          = core_done;
  assign pop           = m_axis.tvalid && m_axis.tready;

  gcd_stein_core #(
    .DATA_W(DATA_W)
  ) u_core (
    .clk   (aclk),
    .rst   (areset),
    .start (accept),
    .a     (s_axis.tdata[DATA_W-1:0]),
    .b     (s_axis.tdata[2*DATA_W-1:DATA_W]),
    .done  (core_done),
    .r     (core_res)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      rdy_en    <= 1'b0;
      core_busy <= 1'b0;
      tlast_q   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        core_busy <= 1'b1;
        tlast_q   <= s_axis.tlast;
      end else if (core_done) begin
        core_busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset && push) fifo_mem[wr_ptr] <= {tlast_q, core_res};
  end

  assign m_axis.tvalid = (count != '0);
  assign m_axis.tdata  = m_axis.tvalid ? fifo_mem[rd_ptr][DATA_W-1:0] : '0;
  assign m_axis.tlast  = m_axis.tvalid && fifo_mem[rd_ptr][DATA_W];
  assign busy          = core_busy || (count != '0);

  assert property (@(posedge aclk) disable iff (areset) !(push && (count == FULL_CNT)));
  assert property (@(posedge aclk) disable iff (areset) !(pop && (count == '0)));

endmodule

// File: tb/tb_axis_gcd_stream.sv
// tb/tb_axis_gcd_stream.sv - directed and randomised self-checking bench for axis_gcd_stream
module tb_axis_gcd_stream;

  logic aclk = 1'b0;
  logic areset;
  logic busy32;
  logic busy8;

  axis_gcd_stream_if #(.W(64)) s32 ();
  axis_gcd_stream_if #(.W(32)) m32 ();
  axis_gcd_stream_if #(.W(16)) s8 ();
  axis_gcd_stream_if #(.W(8))  m8 ();

  axis_gcd_stream #(.DATA_W(32), .FIFO_DEPTH(4)) dut32 (
    .aclk   (aclk),
    .areset (areset),
    .s_axis (s32),
    .m_axis (m32),
    .busy   (busy32)
  );

  axis_gcd_stream #(.DATA_W(8), .FIFO_DEPTH(2)) dut8 (
    .aclk   (aclk),
    .areset (areset),
    .s_axis (s8),
    .m_axis (m8),
    .busy   (busy8)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int rx_n = 0;
  int sent_n = 0;
  logic [63:0] exp_q[$];
  logic rdy_rand_en = 1'b0;
  logic rdy_rand = 1'b0;
  logic rdy_fix = 1'b0;
  logic stall_prev = 1'b0;
  logic [32:0] stall_val = '0;

  assign m32.tready = rdy_rand_en ? rdy_rand : rdy_fix;
  assign m8.tready  = 1'b1;

  always @(posedge aclk) begin
    #1;
    rdy_rand = 1'($urandom_range(0, 1));
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_gcd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Output monitor: scoreboard compare and hold-while-stalled check
  always @(negedge aclk) begin
    if (areset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", {63'd0, m32.tvalid}, 64'd1);
        check("stall_hold", {31'd0, m32.tlast, m32.tdata}, {31'd0, stall_val});
      end
      if (m32.tvalid && m32.tready) begin
        rx_n++;
        if (exp_q.size() == 0) check("extra_beat", 64'd1, 64'd0);
        else check("beat", {31'd0, m32.tlast, m32.tdata}, exp_q.pop_front());
      end
      stall_prev = m32.tvalid && !m32.tready;
      stall_val  = {m32.tlast, m32.tdata};
    end
  end

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic last,
                        input logic [31:0] expv);
    bit ok;
    ok = 1'b0;
    exp_q.push_back({31'd0, last, expv});
    s32.tdata  = {b, a};
    s32.tlast  = last;
    s32.tvalid = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge aclk);
      if (s32.tready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge aclk);
    #1;
    s32.tvalid = 1'b0;
    s32.tlast  = 1'b0;
    if (ok) sent_n++;
    else check("send_timeout", 64'd0, 64'd1);
  endtask

  // Called right after the accept edge; that edge counts as cycle 1
  task automatic lat_check(input string tag, input int exp_lat);
    int lat;
    lat = 1;
    while (!m32.tvalid && lat < 200) begin
      @(posedge aclk);
      #1;
      lat++;
    end
    check(tag, 64'(lat), 64'(exp_lat));
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge aclk);
      #1;
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] expv);
    int n;
    s8.tdata  = {b, a};
    s8.tlast  = 1'b1;
    s8.tvalid = 1'b1;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!s8.tready && n < 100);
    @(posedge aclk);
    #1;
    s8.tvalid = 1'b0;
    s8.tlast  = 1'b0;
    n = 0;
    while (!m8.tvalid && n < 100) begin
      @(posedge aclk);
      #1;
      n++;
    end
    check(tag, {55'd0, m8.tlast, m8.tdata}, {55'd0, 1'b1, expv});
  endtask

  initial begin
    #990000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int base_sent;
    int base_rx;
    int seen_rdy;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] pa [8];
    logic [31:0] pb [8];
    logic [31:0] pg [8];

    areset     = 1'b1;
    s32.tdata  = '0;
    s32.tvalid = 1'b0;
    s32.tlast  = 1'b0;
    s8.tdata   = '0;
    s8.tvalid  = 1'b0;
    s8.tlast   = 1'b0;

    repeat (3) @(posedge aclk);
    #1;
    check("rst_s_tready", {63'd0, s32.tready}, 64'd0);
    check("rst_m_tvalid", {63'd0, m32.tvalid}, 64'd0);
    check("rst_m_tlast", {63'd0, m32.tlast}, 64'd0);
    check("rst_m_tdata", {32'd0, m32.tdata}, 64'd0);
    check("rst_busy", {63'd0, busy32}, 64'd0);
    check("rst8_s_tready", {63'd0, s8.tready}, 64'd0);
    check("rst8_m_tvalid", {63'd0, m8.tvalid}, 64'd0);
    check("rst8_busy", {63'd0, busy8}, 64'd0);
    areset = 1'b0;
    @(posedge aclk);
    #1;

    // Single pair: 8 RUN steps, so tvalid appears 10 cycles from accept
    rdy_fix = 1'b1;
    send32(32'd48, 32'd18, 1'b1, 32'd6);
    lat_check("lat_48_18", 10);
    wait_drain(100);

    // Zero operands finish in one RUN step
    send32(32'd0, 32'd0, 1'b0, 32'd0);
    lat_check("lat_0_0", 3);
    send32(32'd0, 32'd7, 1'b0, 32'd7);
    lat_check("lat_0_7", 3);
    send32(32'd9, 32'd0, 1'b0, 32'd9);
    lat_check("lat_9_0", 3);
    send32(32'd1, 32'hFFFF_FFFF, 1'b1, 32'd1);
    wait_drain(300);

    // Backpressure: FIFO fills to depth, then input stalls
    pa = '{32'd12, 32'd15, 32'd14, 32'd100, 32'd81, 32'd17, 32'd64, 32'd1000};
    pb = '{32'd8,  32'd25, 32'd21, 32'd75,  32'd27, 32'd13, 32'd48, 32'd600};
    pg = '{32'd4,  32'd5,  32'd7,  32'd25,  32'd27, 32'd1,  32'd16, 32'd200};
    rdy_fix   = 1'b0;
    base_sent = sent_n;
    base_rx   = rx_n;
    fork
      begin
        for (int i = 0; i < 8; i++) send32(pa[i], pb[i], (i == 7), pg[i]);
      end
      begin
        repeat (300) @(posedge aclk);
        #1;
        check("full_accepted", 64'(sent_n - base_sent), 64'd4);
        check("full_s_tready", {63'd0, s32.tready}, 64'd0);
        check("full_m_tvalid", {63'd0, m32.tvalid}, 64'd1);
        check("full_busy", {63'd0, busy32}, 64'd1);
        seen_rdy = 0;
        repeat (20) begin
          @(negedge aclk);
          if (s32.tready) seen_rdy = 1;
        end
        check("full_stays_stalled", 64'(seen_rdy), 64'd0);
        @(posedge aclk);
        #1;
        rdy_fix = 1'b1;
      end
    join
    wait_drain(500);
    check("full_rx_count", 64'(rx_n - base_rx), 64'd8);

    // Random pairs against a Euclid reference with random downstream stalls
    rdy_rand_en = 1'b1;
    base_rx     = rx_n;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) ra = '0;
      if ($urandom_range(0, 15) == 0) rb = '0;
      send32(ra, rb, 1'($urandom_range(0, 1)), ref_gcd(ra, rb));
    end
    wait_drain(2000);
    rdy_rand_en = 1'b0;
    rdy_fix     = 1'b1;
    check("rand_rx_count", 64'(rx_n - base_rx), 64'd1000);

    // Reset mid-RUN with two results queued
    rdy_fix = 1'b0;
    send32(32'd0, 32'd5, 1'b0, 32'd5);
    send32(32'd6, 32'd0, 1'b0, 32'd6);
    send32(32'd1, 32'hFFFF_FFFF, 1'b1, 32'd1);
    repeat (5) @(posedge aclk);
    #1;
    check("pre_rst_queued", {63'd0, m32.tvalid}, 64'd1);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    check("mid_rst_s_tready", {63'd0, s32.tready}, 64'd0);
    check("mid_rst_m_tvalid", {63'd0, m32.tvalid}, 64'd0);
    check("mid_rst_m_tlast", {63'd0, m32.tlast}, 64'd0);
    check("mid_rst_m_tdata", {32'd0, m32.tdata}, 64'd0);
    check("mid_rst_busy", {63'd0, busy32}, 64'd0);
    exp_q.delete();
    areset  = 1'b0;
    rdy_fix = 1'b1;
    base_rx = rx_n;
    repeat (80) @(posedge aclk);
    #1;
    check("post_rst_silent", 64'(rx_n - base_rx), 64'd0);
    send32(32'd35, 32'd21, 1'b1, 32'd7);
    wait_drain(100);
    check("post_rst_rx", 64'(rx_n - base_rx), 64'd1);

    // Narrow instance
    run8("w8_128_64", 8'd128, 8'd64, 8'd64);
    run8("w8_255_255", 8'd255, 8'd255, 8'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
